// File: rtl/register_bank_mp.sv
// Two-read, one-write register bank that sweeps every entry to a known value after reset.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to a matching read port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   INIT  | sweeping init_idx over every entry; reads return 0, user writes dropped
//   READY | normal operation; user writes accepted, reads from the array
module register_bank_mp #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int INIT_INDEX = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] read_register1,
    input  logic [ADDR_W-1:0] read_register2,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy,
    output logic              write_dropped
);

    typedef enum logic {INIT, READY} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   init_idx;
    logic [DATA_W-1:0]   regs [DEPTH];

    logic                user_wr_valid;
    logic                wr_drop;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Writes to a hardwired zero register are ignored, not dropped.
    assign user_wr_valid = write && (state == READY) && in_range(write_register)
                           && !is_zero_reg(write_register);
    assign wr_drop       = write && ((state == INIT) || !in_range(write_register));

    always_comb begin
        mem_we = 1'b0;
        mem_wa = write_register;
        mem_wd = write_data;
        if (state == INIT) begin
            mem_we = reset_n;
            mem_wa = init_idx;
            mem_wd = (INIT_INDEX != 0) ? DATA_W'(init_idx) : '0;
        end else begin
            mem_we = user_wr_valid;
        end
    end

    // The array carries no reset; the INIT sweep defines its contents.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            regs[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= INIT;
            init_idx      <= '0;
            busy          <= 1'b1;
            write_dropped <= 1'b0;
        end else begin
            write_dropped <= wr_drop;
            case (state)
                INIT: begin
                    init_idx <= init_idx + 1'b1;
                    if (init_idx == ADDR_W'(DEPTH - 1)) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= INIT;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] rd;
        rd = '0;
        if (!busy && in_range(a) && !is_zero_reg(a)) begin
`ifdef REGFILE_BYPASS_EN
            if (user_wr_valid && (write_register == a)) begin
                rd = write_data;
            end else begin
                rd = regs[a];
            end
`else
            rd = regs[a];
`endif
        end
        return rd;
    endfunction

    always_comb begin
        read_data1 = read_port(read_register1);
        read_data2 = read_port(read_register2);
    end

endmodule

// File: tb/tb_register_bank_mp.sv
// Directed bench for register_bank_mp: a default instance and a DEPTH=24, ZERO_REG=1 instance.
module tb_register_bank_mp;

    logic        clock;
    logic        reset_n;

    logic [4:0]  rr1, rr2, wr;
    logic [63:0] wd;
    logic        we;
    logic [63:0] rd1, rd2;
    logic        busy, dropped;

    logic [4:0]  rr1b, rr2b, wrb;
    logic [63:0] wdb;
    logic        web;
    logic [63:0] rd1b, rd2b;
    logic        busyb, droppedb;

    int checks   = 0;
    int failures = 0;
    int cnt;

    register_bank_mp u_dut (
        .clock(clock), .reset_n(reset_n),
        .read_register1(rr1), .read_register2(rr2),
        .write_register(wr), .write_data(wd), .write(we),
        .read_data1(rd1), .read_data2(rd2),
        .busy(busy), .write_dropped(dropped)
    );

    register_bank_mp #(.DEPTH(24), .ZERO_REG(1)) u_dut_z (
        .clock(clock), .reset_n(reset_n),
        .read_register1(rr1b), .read_register2(rr2b),
        .write_register(wrb), .write_data(wdb), .write(web),
        .read_data1(rd1b), .read_data2(rd2b),
        .busy(busyb), .write_dropped(droppedb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts edges until busy falls; bounded so a stuck FSM still reaches the summary.
    task automatic wait_init(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rr1 = 5'd2; rr2 = 5'd0; wr = 5'd0; wd = '0; we = 1'b0;
        rr1b = 5'd0; rr2b = 5'd0; wrb = 5'd0; wdb = '0; web = 1'b0;
        #12;
        check_eq("rst_busy", 64'(busy), 64'd1);
        check_eq("rst_dropped", 64'(dropped), 64'd0);
        check_eq("rst_rd1", rd1, 64'd0);

        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        while (busy && cnt < 100) begin
            we = (cnt == 10);
            wr = 5'd3;
            wd = 64'hAAAA;
            tick();
            cnt++;
            if (cnt == 5)  check_eq("busy_rd_zero", rd1, 64'd0);
            if (cnt == 11) check_eq("busy_write_dropped", 64'(dropped), 64'd1);
            if (cnt == 12) check_eq("dropped_one_cycle", 64'(dropped), 64'd0);
            if (cnt == 23) check_eq("z_busy_23", 64'(busyb), 64'd1);
            if (cnt == 24) check_eq("z_busy_24", 64'(busyb), 64'd0);
        end
        we = 1'b0;
        check_eq("init_cycles", 64'(cnt), 64'd32);

        rr1 = 5'd7; rr2 = 5'd31;
        #1;
        check_eq("rd1_idx7", rd1, 64'd7);
        check_eq("rd2_idx31", rd2, 64'd31);
        rr1 = 5'd3;
        #1;
        check_eq("dropped_reg_unchanged", rd1, 64'd3);

        rr1 = 5'd5; rr2 = 5'd6; wr = 5'd5; wd = 64'hDEAD_BEEF; we = 1'b1;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("same_cycle_rd1", rd1, 64'hDEAD_BEEF);
`else
        check_eq("same_cycle_rd1", rd1, 64'd5);
`endif
        check_eq("other_port_rd2", rd2, 64'd6);
        tick();
        we = 1'b0;
        check_eq("next_cycle_rd1", rd1, 64'hDEAD_BEEF);
        check_eq("valid_no_drop", 64'(dropped), 64'd0);

        rr1b = 5'd23; rr2b = 5'd30;
        #1;
        check_eq("z_rd1_idx23", rd1b, 64'd23);
        check_eq("z_rd2_oob", rd2b, 64'd0);
        wrb = 5'd30; wdb = 64'h1234; web = 1'b1;
        #1;
        check_eq("z_oob_no_fwd", rd2b, 64'd0);
        tick();
        check_eq("z_oob_dropped", 64'(droppedb), 64'd1);
        rr1b = 5'd0; wrb = 5'd0; wdb = 64'h1;
        #1;
        check_eq("z_reg0_no_fwd", rd1b, 64'd0);
        tick();
        web = 1'b0;
        check_eq("z_reg0_no_drop", 64'(droppedb), 64'd0);
        check_eq("z_reg0_zero", rd1b, 64'd0);
        rr1b = 5'd1;
        #1;
        check_eq("z_reg1_idx", rd1b, 64'd1);

        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_op_busy", 64'(busy), 64'd1);
        check_eq("rst_mid_op_rd", rd1, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_init_busy", 64'(busy), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        wait_init(cnt);
        check_eq("reinit_cycles", 64'(cnt), 64'd32);
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i);
            #1;
            check_eq($sformatf("reinit_reg%0d", i), rd1, 64'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_bank_mp.md
REGISTER_BANK_MP -- requirements
Module: register_bank_mp

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 64: register width in bits.
REQ-002 The block SHALL have the parameter DEPTH, default 32: number of registers, 2..2^ADDR_W.
REQ-003 The block SHALL have the parameter ADDR_W, default 5: register address width.
REQ-004 The block SHALL have the parameter INIT_INDEX, default 1: 1 = register i initialised to i; 0 = initialised to 0.
REQ-005 The block SHALL have the parameter ZERO_REG, default 0: 1 = register 0 hardwired to zero.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset: clock input 1 (all state on rising edge); reset_n input 1 (async active-low reset).
REQ-007 The block SHALL have these data ports:
- read_register1 input ADDR_W: read port 1 address.
- read_register2 input ADDR_W: read port 2 address.
- write_register input ADDR_W: write address.
- write_data input DATA_W: write data.
- write input 1: write enable.
- read_data1 output DATA_W: read port 1 data.
- read_data2 output DATA_W: read port 2 data.
REQ-008 The block SHALL have these status ports:
- busy output 1: initialisation in progress.
- write_dropped output 1: one-cycle pulse when a write request was discarded.

Function
REQ-009 The FSM SHALL have two states, INIT and READY, and an init counter init_idx of ADDR_W bits.
REQ-010 In INIT, each cycle SHALL write register init_idx with init_idx zero-extended to DATA_W (INIT_INDEX=1) or with 0 (INIT_INDEX=0), then increment init_idx.
REQ-011 When init_idx == DEPTH-1 is written, the FSM SHALL move to READY on that edge; busy SHALL be 1 in INIT and 0 in READY, so busy is high for exactly DEPTH cycles after reset release.
REQ-012 In READY, write=1 SHALL update register write_register with write_data at the rising edge (one-cycle write latency).
REQ-013 Reads SHALL be combinational with zero latency and have no modelled delay; both ports are independent, and identical addresses are allowed.
REQ-014 While busy=1, read_data1/2 SHALL be 0 and user writes SHALL be discarded.
REQ-015 A discarded write SHALL pulse write_dropped high for the following cycle; this covers write=1 while busy, and write=1 with write_register >= DEPTH.
REQ-016 Address >= DEPTH on a read port SHALL return 0.
REQ-017 With ZERO_REG=1, reads of address 0 SHALL return 0, and writes to address 0 SHALL be silently ignored without a write_dropped pulse; INIT still steps through address 0.
REQ-018 Simultaneous read and write of the same address: behaviour SHALL be as defined in the Configuration section; reads of other addresses are unaffected.
REQ-019 write_data and write_register SHALL be sampled only at the edge; register contents SHALL change only on the rising edge.

Reset
REQ-020 reset_n=0 SHALL immediately force state=INIT, init_idx=0, busy=1, write_dropped=0, read_data1/2=0.
REQ-021 The register array SHALL NOT be reset directly; its contents are defined only after the INIT sweep completes.
REQ-022 reset_n asserted mid-INIT or mid-operation SHALL abort the sweep and restart it from index 0 after release; any write in progress at assertion is lost.
REQ-023 The first INIT write SHALL occur on the first rising edge with reset_n=1.

Configuration
REQ-024 The macro REGFILE_BYPASS_EN, when defined, SHALL enable write-to-read forwarding: in READY, with write=1 and a valid, non-ignored write_register equal to a read address, that read port returns write_data combinationally in the same cycle.
REQ-025 When REGFILE_BYPASS_EN is undefined, a read of the address being written SHALL return the old value until after the edge, and the new value from the next cycle.
REQ-026 Forwarding SHALL never apply while busy, to dropped writes, or to address 0 when ZERO_REG=1.

Verification
REQ-027 Reset release, DEPTH=32, INIT_INDEX=1 -> busy high exactly 32 cycles; afterwards read_register1=7 gives read_data1=7, and read_register2=31 gives read_data2=31.
REQ-028 In READY, write=1, write_register=5, write_data=64'hDEAD_BEEF, read_register1=5 in the same cycle -> read_data1=DEADBEEF same cycle with REGFILE_BYPASS_EN, 5 without; DEADBEEF in the next cycle in both builds.
REQ-029 write=1 at cycle 10 after reset release (busy) -> write_dropped=1 at cycle 11, register unchanged after INIT completes.
REQ-030 ZERO_REG=1, write register 0 with 64'h1 -> read_data1=0, write_dropped stays 0.
REQ-031 reset_n pulsed low at INIT index 12 -> busy stays high for a further full 32 cycles after release, and all registers equal their index.
REQ-032 DEPTH=24, read_register2=30 -> read_data2=0; write to 30 -> write_dropped pulses.
